pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Generic parametrised pipeline stage register for the RV32 pipeline. It is the successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latch modules. It carries a CTRL_W-bit control bundle and a DATA_W-bit data bundle between two pipeline stages using a valid/ready handshake, with synchronous flush (bubble insertion), backpressure and a saturating stall-cycle counter. One instance per stage boundary; the widths are set per boundary.

## Interface
- CTRL_W, 9: control bundle width (branch, memRead, …); zeroed on flush.
- DATA_W, 101: data bundle width (pc, operands, immediate, rd, …).
- CNT_W, 16: stall counter width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream stage presents an entry.
- in_ready  output  1  stage can accept; a transfer occurs when in_valid && in_ready at the clk edge.
- in_ctrl  input  CTRL_W  control bundle.
- in_data  input  DATA_W  data bundle.
- flush  input  1  synchronous kill of all held entries and of any entry arriving this cycle.
- out_valid  output  1  entry held for the downstream stage.
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- out_ctrl  output  CTRL_W  held control; all-zero whenever out_valid=0.
- out_data  output  DATA_W  held data.
- stall_cnt  output  CNT_W  cycles with out_valid && !out_ready.

## Operation
- Main register (m_valid, m_ctrl, m_data) drives out_*. out_ctrl = m_valid ? m_ctrl : 0, so a bubble never asserts regWrite, memWrite or any other control bit.
- Accept: on an in-transfer, the entry loads into main if main is empty or draining this cycle (out-transfer). Otherwise it loads into the skid register (skid config only).
- Hold: when main is full and no out-transfer occurs, main keeps its ctrl and data unchanged.
- Flush priority: highest, above accept and hold. On the flush edge:
  - m_valid and s_valid clear.
  - Any in-transfer that cycle is dropped.
  - m_data is not cleared; out_ctrl reads 0 through the valid gate.
  - An out-transfer in the same cycle still counts as completed downstream.
- Ordering: entries leave in arrival order, always. The skid entry moves to main on the edge where main drains.
- stall_cnt: increments by 1 each edge where out_valid && !out_ready && !flush. It saturates at 2^CNT_W−1 and clears only on reset.
- Reset (rst_n=0, asynchronous): m_valid=0, s_valid=0, m_ctrl=0, m_data=0, stall_cnt=0. Outputs: out_valid=0, out_ctrl=0, out_data=0, in_ready=1.

## Timing
- Latency: an entry accepted at edge N appears on out_* after edge N, i.e. valid in cycle N+1.
- Throughput: 1 entry per cycle while out_ready=1.
- Without skid: in_ready = !m_valid || out_ready. This is a combinational path from out_ready.
- With skid: in_ready = !s_valid, registered, so there is no combinational path from out_ready.
  - Capacity 2 entries.
  - in_ready falls on the edge after the first blocked acceptance and rises on the edge after the skid drains.
- Flush takes effect at the edge it is sampled. out_valid is 0 in the following cycle.
- Reset deassertion: the first accept can occur at the first rising edge with rst_n=1.

## Configuration
- PIPE_STAGE_SKID_EN defined: 2-entry stage with skid register; in_ready is registered as described above.
- PIPE_STAGE_SKID_EN undefined: single-entry stage.
  - No skid register is synthesised.
  - in_ready is combinational.
  - An input arriving while main is full and not draining sees in_ready=0 and is not accepted.

## Test plan
- Reset mid-stream: drive 3 entries (data 0x1, 0x2, 0x3), assert rst_n=0 between edges -> out_valid, out_ctrl and stall_cnt go to 0 immediately without waiting for clk; in_ready=1.
- Streaming: in_valid=1 every cycle with data 0..9, out_ready=1 -> out_data 0..9 on consecutive cycles, each one cycle after acceptance; stall_cnt=0.
- Backpressure: hold out_ready=0 for 4 cycles with entry 0xA held and 0xB offered.
  - Skid config: 0xB accepted, in_ready=0 from next cycle, stall_cnt=4, then 0xA and 0xB delivered in order.
  - Non-skid config: 0xB not accepted until out_ready=1.
- Flush with simultaneous input: main holds ctrl=0x1FF, skid holds an entry, in_valid=1, flush=1 -> next cycle out_valid=0, out_ctrl=0, and neither entry nor the incoming one ever appears.
- Counter saturation: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt stops at 15.
- Bubble control gating: in_valid=0 with in_ctrl=0x1FF for 3 cycles -> out_ctrl=0 on all 3 cycles.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Purpose: generic RV32 pipeline stage register carrying a control and a data bundle, with flush and stall counter.
// Latency: 1 cycle from in-transfer to out_valid; 1 entry/cycle throughput while out_ready=1.
// Backpressure: single entry with combinational in_ready by default; PIPE_STAGE_SKID_EN adds a skid entry and registered in_ready.
module pipe_stage_reg #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 101,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              m_valid_q, m_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic [CNT_W-1:0]  stall_q,   stall_d;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = m_valid_q && out_ready;

    // A bubble never presents control bits downstream; data is left ungated.
    assign out_valid = m_valid_q;
    assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
    assign out_data  = m_data_q;
    assign stall_cnt = stall_q;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;

    // Registered ready: only the skid occupancy gates the upstream.
    assign in_ready = !s_valid_q;

    // Next state for main and skid: flush wins, then drain/refill, then skid capture.
    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_ctrl_d  = s_ctrl_q;
        s_data_d  = s_data_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || out_xfer) begin
            // Main is free this edge; the older skid entry goes first.
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = s_ctrl_q;
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else if (in_xfer) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = in_ctrl;
                m_data_d  = in_data;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            // Main is held: park the arriving entry in the skid slot.
            s_valid_d = 1'b1;
            s_ctrl_d  = in_ctrl;
            s_data_d  = in_data;
        end
    end

    // Skid register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid_q <= 1'b0;
            s_ctrl_q  <= '0;
            s_data_q  <= '0;
        end else begin
            s_valid_q <= s_valid_d;
            s_ctrl_q  <= s_ctrl_d;
            s_data_q  <= s_data_d;
        end
    end
`else
    // Single-entry stage: accept when empty or draining; combinational from out_ready.
    assign in_ready = !m_valid_q || out_ready;

    // Next state for main: flush wins, then load, then drain.
    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        if (flush) begin
            m_valid_d = 1'b0;
        end else if (in_xfer) begin
            m_valid_d = 1'b1;
            m_ctrl_d  = in_ctrl;
            m_data_d  = in_data;
        end else if (out_xfer) begin
            m_valid_d = 1'b0;
        end
    end
`endif

    // Stall counter: counts blocked cycles that are not flushed, saturating at all-ones.
    always_comb begin
        stall_d = stall_q;
        if (m_valid_q && !out_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Main register and stall counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_ctrl_q  <= '0;
            m_data_q  <= '0;
            stall_q   <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_ctrl_q  <= m_ctrl_d;
            m_data_q  <= m_data_d;
            stall_q   <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (CNT_W=4 so saturation is reachable quickly).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Skid-dependent expectations follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 9;
    localparam int DATA_W = 101;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int tests = 0;
    int fails = 0;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall", stall_cnt, 0);
        rst_n = 1'b1;

        // Streaming 0..9, first accept on the first edge after reset release
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i);
            in_ctrl  = CTRL_W'(i + 1);
            chk("stream_in_ready", in_ready, 1);
            step();
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, 128'(i));
            chk("stream_ctrl", out_ctrl, 128'(i + 1));
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_valid", out_valid, 0);
        chk("stream_stall", stall_cnt, 0);

        // Bubble control gating
        in_ctrl = 9'h1FF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bubble_ctrl", out_ctrl, 0);
            chk("bubble_valid", out_valid, 0);
        end

        // Backpressure: 0xA held, 0xB offered, out_ready=0 for 4 cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 'hA;
        in_ctrl   = 9'h00A;
        step();
        chk("bp_a_valid", out_valid, 1);
        chk("bp_a_data", out_data, 'hA);
        chk("bp_stall0", stall_cnt, 0);
        in_data = 'hB;
        in_ctrl = 9'h00B;
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_in_ready_pre", in_ready, 1);
`else
        chk("bp_in_ready_pre", in_ready, 0);
`endif
        for (int k = 1; k <= 4; k++) begin
            step();
`ifdef PIPE_STAGE_SKID_EN
            in_valid = 1'b0;
`endif
            chk("bp_stall", stall_cnt, 128'(k));
            chk("bp_hold_data", out_data, 'hA);
            chk("bp_hold_ctrl", out_ctrl, 'h00A);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_in_ready_reg", in_ready, 0);
        step();
        chk("bp_b_valid", out_valid, 1);
        chk("bp_b_data", out_data, 'hB);
        chk("bp_in_ready_back", in_ready, 1);
`else
        chk("bp_in_ready_comb", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_b_valid", out_valid, 1);
        chk("bp_b_data", out_data, 'hB);
`endif
        step();
        chk("bp_drained", out_valid, 0);
        chk("bp_stall_final", stall_cnt, 4);

        // Flush with simultaneous input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 9'h1FF;
        in_data   = 'h11;
        step();
        chk("fl_main_ctrl", out_ctrl, 'h1FF);
        in_ctrl = 9'h022;
        in_data = 'h22;
        step();
        chk("fl_stall", stall_cnt, 5);
        in_ctrl   = 9'h033;
        in_data   = 'h33;
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl", out_ctrl, 0);
        chk("fl_data_kept", out_data, 'h11);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_stall_after", stall_cnt, 5);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_nothing", out_valid, 0);
        end

        // Reset mid-stream after driving 0x1..0x3
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i);
            in_ctrl  = 9'h0F0;
            step();
        end
        chk("mr_pre_data", out_data, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_ctrl", out_ctrl, 0);
        chk("mr_stall", stall_cnt, 0);
        chk("mr_in_ready", in_ready, 1);
        #1;
        rst_n   = 1'b1;
        in_data = 'h55;
        step();
        chk("mr_first_accept", out_data, 'h55);
        chk("mr_first_valid", out_valid, 1);

        // Counter saturation at 15
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("sat_stall", stall_cnt, (k > 15) ? 128'd15 : 128'(k));
        end
        chk("sat_valid", out_valid, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
